// File: rtl/chip_spi_resp.sv
// chip_spi_resp: serial command receiver, ADC conversion handshake and
// serial result transmitter towards the FPGA.
// Ports: clk, rst (async, active high); command side spi_so2chip_flag,
//   dout_2_chip; result side spi_fpga_wait, spi_si4chip_ena, din_4_chip;
//   converter adc_done, adc_data, adc_start; decoded pixel_select,
//   rotate_flag, adc_int_flag; status cmd_valid, frame_err, busy.
// Optional macro CONV_TIMEOUT_EN: abandon a conversion after TIMEOUT_CYC
//   cycles and send the sentinel word instead.
module chip_spi_resp #(
    parameter int WORD_WIDTH   = 18,
    parameter int ADDR_WIDTH   = 8,
    parameter int ROTAT_LOCA   = 17,
    parameter int ADC_INT_LOCA = 16,
    parameter int ADC_BITS     = 18,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_so2chip_flag,
    input  logic                  dout_2_chip,
    input  logic                  spi_fpga_wait,
    input  logic                  adc_done,
    input  logic [ADC_BITS-1:0]   adc_data,
    output logic                  spi_si4chip_ena,
    output logic                  din_4_chip,
    output logic [ADDR_WIDTH-1:0] pixel_select,
    output logic                  rotate_flag,
    output logic                  adc_int_flag,
    output logic                  cmd_valid,
    output logic                  frame_err,
    output logic                  adc_start,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE, RX_LEAD, RX_SHIFT, CONVERT, WAIT_RDY, TX_SHIFT
    } state_t;

    localparam int MAX_A = (WORD_WIDTH > ADC_BITS) ? WORD_WIDTH : ADC_BITS;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CNT_W = $clog2(MAX_C + 1);
`ifdef CONV_TIMEOUT_EN
    localparam logic [ADC_BITS-1:0] SENTINEL = ADC_BITS'(18'h2AAAA);
`endif

    state_t                  state, state_d;
    logic                    armed, armed_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [WORD_WIDTH-2:0]   shreg, shreg_d;
    logic [ADC_BITS-1:0]     result, result_d;
    logic                    conv_first, conv_first_d;
    logic                    ena_d, din_d;
    logic [ADDR_WIDTH-1:0]   pix_d;
    logic                    rot_d, int_d;
    logic                    cv_d, fe_d, start_d, busy_d;
    logic [WORD_WIDTH-1:0]   word;

    always_comb begin
        state_d      = state;
        armed_d      = armed;
        cnt_d        = cnt;
        shreg_d      = shreg;
        result_d     = result;
        conv_first_d = conv_first;
        ena_d        = spi_si4chip_ena;
        din_d        = din_4_chip;
        pix_d        = pixel_select;
        rot_d        = rotate_flag;
        int_d        = adc_int_flag;
        cv_d         = 1'b0;
        fe_d         = 1'b0;
        start_d      = 1'b0;
        word         = {shreg, dout_2_chip};
        unique case (state)
            IDLE: begin
                // A frame may only start once the flag was seen low here.
                if (!spi_so2chip_flag) begin
                    armed_d = 1'b1;
                end else if (armed) begin
                    armed_d = 1'b0;
                    state_d = RX_LEAD;
                end
            end
            RX_LEAD: begin
                if (!spi_so2chip_flag) begin
                    state_d = IDLE;
                end else begin
                    state_d = RX_SHIFT;
                    cnt_d   = '0;
                end
            end
            RX_SHIFT: begin
                if (!spi_so2chip_flag) begin
                    fe_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    shreg_d = word[WORD_WIDTH-2:0];
                    cnt_d   = cnt + 1'b1;
                    if (cnt == CNT_W'(WORD_WIDTH - 1)) begin
                        pix_d        = word[ADDR_WIDTH-1:0];
                        rot_d        = word[ROTAT_LOCA];
                        int_d        = word[ADC_INT_LOCA];
                        cv_d         = 1'b1;
                        cnt_d        = '0;
                        conv_first_d = 1'b1;
                        state_d      = CONVERT;
                    end
                end
            end
            CONVERT: begin
                // adc_done is ignored while the start pulse is issued.
                if (conv_first) begin
                    start_d      = 1'b1;
                    conv_first_d = 1'b0;
`ifdef CONV_TIMEOUT_EN
                    cnt_d        = cnt + 1'b1;
`endif
                end else if (adc_done) begin
                    result_d = adc_data;
                    state_d  = WAIT_RDY;
`ifdef CONV_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    result_d = SENTINEL;
                    state_d  = WAIT_RDY;
                end else begin
                    cnt_d = cnt + 1'b1;
`endif
                end
            end
            WAIT_RDY: begin
                if (spi_fpga_wait) begin
                    ena_d    = 1'b1;
                    din_d    = result[ADC_BITS-1];
                    result_d = {result[ADC_BITS-2:0], 1'b0};
                    cnt_d    = '0;
                    state_d  = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                // MSB already on the line; cnt counts bits after it.
                if (cnt == CNT_W'(ADC_BITS - 1)) begin
                    ena_d   = 1'b0;
                    din_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    din_d    = result[ADC_BITS-1];
                    result_d = {result[ADC_BITS-2:0], 1'b0};
                    cnt_d    = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            armed           <= 1'b0;
            cnt             <= '0;
            shreg           <= '0;
            result          <= '0;
            conv_first      <= 1'b0;
            spi_si4chip_ena <= 1'b0;
            din_4_chip      <= 1'b0;
            pixel_select    <= '0;
            rotate_flag     <= 1'b0;
            adc_int_flag    <= 1'b0;
            cmd_valid       <= 1'b0;
            frame_err       <= 1'b0;
            adc_start       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_d;
            armed           <= armed_d;
            cnt             <= cnt_d;
            shreg           <= shreg_d;
            result          <= result_d;
            conv_first      <= conv_first_d;
            spi_si4chip_ena <= ena_d;
            din_4_chip      <= din_d;
            pixel_select    <= pix_d;
            rotate_flag     <= rot_d;
            adc_int_flag    <= int_d;
            cmd_valid       <= cv_d;
            frame_err       <= fe_d;
            adc_start       <= start_d;
            busy            <= busy_d;
        end
    end

endmodule

// File: tb/tb_chip_spi_resp.sv
// tb_chip_spi_resp: table-driven and randomized bench for chip_spi_resp.
// Expected values come from a transaction-level model of the protocol.
module tb_chip_spi_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag;
    logic        dout;
    logic        fpga_wait;
    logic        done;
    logic [17:0] data;
    logic        ena;
    logic        din;
    logic [7:0]  pix;
    logic        rot;
    logic        aint;
    logic        cmd_valid;
    logic        frame_err;
    logic        adc_start;
    logic        busy;

    always #5 clk = ~clk;

    chip_spi_resp dut (
        .clk              (clk),
        .rst              (rst),
        .spi_so2chip_flag (flag),
        .dout_2_chip      (dout),
        .spi_fpga_wait    (fpga_wait),
        .adc_done         (done),
        .adc_data         (data),
        .spi_si4chip_ena  (ena),
        .din_4_chip       (din),
        .pixel_select     (pix),
        .rotate_flag      (rot),
        .adc_int_flag     (aint),
        .cmd_valid        (cmd_valid),
        .frame_err        (frame_err),
        .adc_start        (adc_start),
        .busy             (busy)
    );

    typedef struct {
        logic [17:0] word;
        int          nbits;
        logic [17:0] rdata;
        bit          hold;
        logic [7:0]  e_pix;
        logic        e_rot;
        logic        e_int;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   n_cv = 0;
    int   n_fe = 0;
    int   ena_runs = 0;
    int   bad_din = 0;
    bit   ena_q = 1'b0;
    logic tx_q[$];

    // Model state: decoded outputs currently expected from the DUT.
    logic [7:0] m_pix;
    logic       m_rot;
    logic       m_int;

    always @(negedge clk) begin
        if (cmd_valid) n_cv++;
        if (frame_err) n_fe++;
        if (ena) tx_q.push_back(din);
        if (ena && !ena_q) ena_runs++;
        if (!ena && din) bad_din++;
        ena_q = ena;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [17:0] w, input int nbits);
        flag = 1'b0;
        step();
        flag = 1'b1;
        step();
        step();
        for (int k = 0; k < nbits; k++) begin
            dout = w[17-k];
            step();
        end
    endtask

    task automatic do_frame(input logic [17:0] w, input int nbits,
                            input logic [17:0] d, input bit hold,
                            input bit noise, input logic [7:0] e_pix,
                            input logic e_rot, input logic e_int,
                            input int done_dly, input int wait_dly);
        int          cv0;
        int          fe0;
        int          runs0;
        int          base;
        int          i;
        logic [31:0] val;
        cv0       = n_cv;
        fe0       = n_fe;
        runs0     = ena_runs;
        fpga_wait = 1'b0;
        done      = 1'b0;
        send_bits(w, nbits);
        if (nbits < 18) begin
            flag = 1'b0;
            dout = 1'b0;
            step();
            chk("err_pulse", frame_err, 1);
            chk("err_busy", busy, 0);
            chk("err_pix", pix, e_pix);
            chk("err_rot", rot, e_rot);
            chk("err_int", aint, e_int);
            step();
            chk("err_pulse_end", frame_err, 0);
            chk("err_fe_cnt", n_fe - fe0, 1);
            chk("err_cv_cnt", n_cv - cv0, 0);
            return;
        end
        chk("cv_pulse", cmd_valid, 1);
        chk("dec_pix", pix, e_pix);
        chk("dec_rot", rot, e_rot);
        chk("dec_int", aint, e_int);
        chk("busy_conv", busy, 1);
        if (!hold) flag = 1'b0;
        step();
        chk("adc_start", adc_start, 1);
        chk("cv_end", cmd_valid, 0);
        step();
        chk("adc_start_end", adc_start, 0);
        for (int k = 0; k < done_dly; k++) begin
            if (noise) begin
                flag = 1'($urandom_range(0, 1));
                dout = 1'($urandom_range(0, 1));
            end
            step();
        end
        if (!hold) flag = 1'b0;
        data = d;
        done = 1'b1;
        step();
        done = 1'b0;
        data = 18'($urandom);
        for (int k = 0; k < wait_dly; k++) step();
        base      = tx_q.size();
        fpga_wait = 1'b1;
        i         = 0;
        while (i < 200 && !(tx_q.size() > base && !ena)) begin
            step();
            i++;
        end
        fpga_wait = 1'b0;
        chk("tx_bound", i < 200, 1);
        val = 0;
        for (int k = base; k < tx_q.size(); k++) val = val * 2 + tx_q[k];
        chk("tx_len", tx_q.size() - base, 18);
        chk("tx_val", val, d);
        chk("tx_runs", ena_runs - runs0, 1);
        chk("tx_idle", busy, 0);
        chk("txn_cv_cnt", n_cv - cv0, 1);
        chk("txn_fe_cnt", n_fe - fe0, 0);
        if (hold) begin
            step();
            step();
            step();
            chk("hold_ignored", busy, 0);
            flag = 1'b0;
        end
    endtask

    vec_t        tbl[7];
    int          i;
    int          base;
    int          cv0;
    int          fe0;
    int          runs0;
    int          nb;
    logic [17:0] w;
    logic [17:0] d;
    logic [31:0] val;

    initial begin
        tbl[0] = '{18'h20703, 18, 18'h1F00F, 1'b0, 8'h03, 1'b1, 1'b0};
        tbl[1] = '{18'h100A5, 18, 18'h3FFFF, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[2] = '{18'h3FFFF, 10, 18'h00000, 1'b0, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{18'h000FF, 18, 18'h00000, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{18'h30001,  1, 18'h00000, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[5] = '{18'h3C35A, 18, 18'h15555, 1'b0, 8'h5A, 1'b1, 1'b1};
        tbl[6] = '{18'h01234, 17, 18'h00000, 1'b0, 8'h5A, 1'b1, 1'b1};

        rst       = 1'b1;
        flag      = 1'b0;
        dout      = 1'b0;
        fpga_wait = 1'b0;
        done      = 1'b0;
        data      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ena", ena, 0);
        chk("rst_din", din, 0);
        chk("rst_pix", pix, 0);
        chk("rst_flags", {rot, aint, cmd_valid, frame_err, adc_start}, 0);
        chk("rst_busy", busy, 0);
        #3 rst = 1'b0;

        for (int r = 0; r < 7; r++) begin
            do_frame(tbl[r].word, tbl[r].nbits, tbl[r].rdata, tbl[r].hold,
                     1'b0, tbl[r].e_pix, tbl[r].e_rot, tbl[r].e_int, 1, 0);
        end
        m_pix = tbl[6].e_pix;
        m_rot = tbl[6].e_rot;
        m_int = tbl[6].e_int;

        // Randomized transactions against the model.
        for (int r = 0; r < 16; r++) begin
            w  = 18'($urandom);
            d  = 18'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 17) : 18;
            if (nb == 18) begin
                m_pix = 8'(w % 256);
                m_rot = 1'((w >> 17) & 1);
                m_int = 1'((w >> 16) & 1);
            end
            do_frame(w, nb, d, 1'b0, 1'($urandom_range(0, 1)),
                     m_pix, m_rot, m_int,
                     $urandom_range(0, 5), $urandom_range(0, 4));
        end

        // Reset in the middle of a result frame.
        send_bits(18'h20703, 18);
        flag = 1'b0;
        step();
        step();
        data = 18'h3FFFF;
        done = 1'b1;
        step();
        done      = 1'b0;
        fpga_wait = 1'b1;
        i = 0;
        while (i < 50 && !ena) begin
            step();
            i++;
        end
        chk("rst_tx_started", ena, 1);
        repeat (9) step();
        flag = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_ena", ena, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_din", din, 0);
        chk("midrst_pix", {rot, pix}, 0);
        #4 rst = 1'b0;
        fpga_wait = 1'b0;
        cv0 = n_cv;
        fe0 = n_fe;
        repeat (5) step();
        chk("held_flag_ignored", busy, 0);
        flag = 1'b0;
        step();
        flag = 1'b1;
        step();
        chk("restart_after_low", busy, 1);
        flag = 1'b0;
        step();
        chk("lead_abort_idle", busy, 0);
        step();
        chk("lead_abort_no_err", n_fe - fe0, 0);
        chk("lead_abort_no_cv", n_cv - cv0, 0);

        // Conversion that never completes.
        send_bits(18'h0F1E0, 18);
        flag = 1'b0;
        step();
        step();
        runs0     = ena_runs;
        base      = tx_q.size();
        fpga_wait = 1'b1;
`ifdef CONV_TIMEOUT_EN
        i = 0;
        while (i < 400 && !ena) begin
            step();
            i++;
        end
        chk("timeout_latency", (i >= 250 && i <= 260), 1);
        i = 0;
        while (i < 40 && ena) begin
            step();
            i++;
        end
        val = 0;
        for (int k = base; k < tx_q.size(); k++) val = val * 2 + tx_q[k];
        chk("timeout_len", tx_q.size() - base, 18);
        chk("timeout_val", val, 32'h2AAAA);
        chk("timeout_idle", busy, 0);
`else
        repeat (1000) step();
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_tx", ena_runs - runs0, 0);
        chk("no_timeout_bits", tx_q.size() - base, 0);
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        step();
        chk("no_timeout_rst", busy, 0);
`endif
        fpga_wait = 1'b0;
        step();
        chk("din_low_when_idle", bad_din, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
